updn_sweep_ctrl: RTL and testbench
==================================

Name: updn_sweep_ctrl

Overview:
- Sequencer for the team's up/down counter datapath.
- Drives an internal WIDTH-bit up/down counter through a programmed number of triangular sweeps: lo -> hi -> lo.
- Exports the counter mode code (0 down, 1 up, 2 hold) so downstream logic can mirror or log it.
- Sits between a configuration/control master (start/abort) and count consumers (DAC ramps, test pattern generators).

Parameters:
- WIDTH, 8, counter and bound width (unsigned).
- CYC_W, 4, width of the sweep-count field.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- start  input  1  one-cycle request to begin a run; sampled only in IDLE.
- abort  input  1  stop the run immediately; sampled in every state.
- lo  input  WIDTH  lower bound; latched on an accepted start.
- hi  input  WIDTH  upper bound; latched on an accepted start.
- n_sweeps  input  CYC_W  number of full sweeps; latched on an accepted start.
- count  output  WIDTH  current counter value.
- mod  output  2  mode code: 0 = DOWN, 1 = UP, 2 = HOLD.
- busy  output  1  high in UP and DOWN.
- done  output  1  one-cycle pulse on normal completion.
- cfg_err  output  1  one-cycle pulse when a start is rejected.
- sweeps  output  CYC_W  completed sweeps in the current or last run.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, count=0, mod=2, busy=0, done=0, cfg_err=0, sweeps=0, latched bounds=0.
- States: IDLE, UP, DOWN, DONE. All outputs are registered.
- IDLE:
  - mod=2; count holds.
  - start=1 with lo<hi and n_sweeps!=0: latch lo/hi/n; next cycle count=lo, sweeps=0, state=UP.
  - start=1 with lo>=hi or n_sweeps==0: cfg_err pulses 1 cycle; stay in IDLE; count and sweeps unchanged.
- UP:
  - mod=1, busy=1; count<=count+1 each cycle.
  - When count+1==hi: next state=DOWN, so count reaches hi on the last UP cycle.
- DOWN:
  - mod=0, busy=1; count<=count-1 each cycle.
  - When count-1==lo: sweeps<=sweeps+1.
  - Then if sweeps+1==n: next state=DONE; otherwise next state=UP.
- DONE:
  - done=1 for exactly one cycle; mod=2, busy=0; count holds at lo.
  - Next state=IDLE.
- Timing:
  - One sweep takes 2*(hi-lo) cycles.
  - A run takes 1 (start->UP) + n*2*(hi-lo) + 1 (DONE) cycles.
- Count never leaves [lo, hi]; no wrap-around is possible, because lo<hi is enforced at start.
- start outside IDLE: ignored. Latched bounds are stable for the whole run; live lo/hi/n changes have no effect.
- abort=1 in UP, DOWN or DONE:
  - Next state=IDLE; count frozen at its current value; sweeps frozen; done not asserted.
  - abort wins over start in the same cycle; abort in IDLE has no effect.
- Reset mid-run: immediate return to reset values; no done pulse.
- hi = 2^WIDTH-1 is legal; count+1/count-1 comparisons are done at WIDTH+1 bits so there is no overflow.

Optional Feature:
- Macro: SWEEP_PAUSE_EN.
- Defined:
  - Adds input pause (1 bit).
  - pause=1 in UP or DOWN freezes count, sweeps and state; mod=2 and busy stays 1 while paused.
  - Release resumes on the next edge with no lost or duplicated steps.
  - abort overrides pause.
- Undefined: no pause port; UP/DOWN always advance every cycle.

Test Plan:
- Reset then lo=2, hi=5, n=2, start pulse -> count 2,3,4,5,4,3,2,3,4,5,4,3,2 on consecutive cycles; done pulses once at cycle 14 after start; sweeps=2; mod=2 after.
- start with lo=7, hi=7, n=3 -> cfg_err 1-cycle pulse, state stays IDLE, busy=0, count unchanged; repeat with n=0, lo=1, hi=4 -> same.
- lo=0, hi=255 (WIDTH=8), n=1 -> reaches 255 without wrap, returns to 0; run lasts 512 cycles; done=1 once.
- abort asserted at count=4 during the DOWN phase of a lo=1, hi=6, n=3 run -> IDLE next cycle, count stays 4, sweeps stays 0, done never pulses; a start pulse during busy is ignored.
- Assert rst low mid-run at count=3 -> count=0, mod=2, busy=0 immediately (asynchronous), with no clock edge needed.
- SWEEP_PAUSE_EN: pause for 5 cycles at count=3 during UP -> count stays 3, mod=2; after release the sequence continues 4,5,... and total run length grows by exactly 5 cycles.

Source files
------------

// File: rtl/updn_sweep_ctrl.sv
// rtl/updn_sweep_ctrl.sv - up/down counter sequencer running n triangular lo->hi->lo sweeps
// Optional pause input when SWEEP_PAUSE_EN is defined.
module updn_sweep_ctrl #(
    parameter int WIDTH = 8,
    parameter int CYC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
`ifdef SWEEP_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [CYC_W-1:0] n_sweeps,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       mod,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [CYC_W-1:0] sweeps
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MOD_DOWN = 2'd0;
    localparam logic [1:0] MOD_UP   = 2'd1;
    localparam logic [1:0] MOD_HOLD = 2'd2;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
    logic [CYC_W-1:0] n_q, n_d, sweeps_q, sweeps_d, sweeps_inc;
    logic [1:0]       mod_q, mod_d;
    logic             busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
    logic             paused, hold;
    logic [WIDTH:0]   count_inc, count_dec;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        sweeps_d   = sweeps_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        n_d        = n_q;
        cfg_err_d  = 1'b0;
        hold       = 1'b0;
`ifdef SWEEP_PAUSE_EN
        paused     = pause;
`else
        paused     = 1'b0;
`endif
        // one extra bit so hi = 2^WIDTH-1 compares without overflow
        count_inc  = {1'b0, count_q} + 1'b1;
        count_dec  = {1'b0, count_q} - 1'b1;
        sweeps_inc = sweeps_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if ((lo < hi) && (n_sweeps != '0)) begin
                        lo_d     = lo;
                        hi_d     = hi;
                        n_d      = n_sweeps;
                        count_d  = lo;
                        sweeps_d = '0;
                        state_d  = S_UP;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_UP: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (paused) begin
                    hold = 1'b1;
                end else begin
                    count_d = count_inc[WIDTH-1:0];
                    if (count_inc == {1'b0, hi_q}) state_d = S_DOWN;
                end
            end
            S_DOWN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (paused) begin
                    hold = 1'b1;
                end else begin
                    count_d = count_dec[WIDTH-1:0];
                    if (count_dec == {1'b0, lo_q}) begin
                        sweeps_d = sweeps_inc;
                        state_d  = (sweeps_inc == n_q) ? S_DONE : S_UP;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // outputs are registered, so they are derived from the state being entered
        busy_d = (state_d == S_UP) || (state_d == S_DOWN);
        done_d = (state_d == S_DONE);
        if (hold)                   mod_d = MOD_HOLD;
        else if (state_d == S_UP)   mod_d = MOD_UP;
        else if (state_d == S_DOWN) mod_d = MOD_DOWN;
        else                        mod_d = MOD_HOLD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            n_q       <= '0;
            sweeps_q  <= '0;
            mod_q     <= MOD_HOLD;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            n_q       <= n_d;
            sweeps_q  <= sweeps_d;
            mod_q     <= mod_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign count   = count_q;
    assign mod     = mod_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cfg_err = cfg_err_q;
    assign sweeps  = sweeps_q;

endmodule

// File: tb/tb_updn_sweep_ctrl.sv
// tb/tb_updn_sweep_ctrl.sv - table-driven and randomized checks of updn_sweep_ctrl
module tb_updn_sweep_ctrl;
    localparam int WIDTH = 8;
    localparam int CYC_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
`ifdef SWEEP_PAUSE_EN
    logic             pause = 1'b0;
`endif
    logic [WIDTH-1:0] lo = '0;
    logic [WIDTH-1:0] hi = '0;
    logic [CYC_W-1:0] n_sweeps = '0;
    logic [WIDTH-1:0] count;
    logic [1:0]       mod;
    logic             busy, done, cfg_err;
    logic [CYC_W-1:0] sweeps;

    int n_vec = 0;
    int n_err = 0;
    int exp_idle_count = 0;
    int exp_idle_sweeps = 0;

    typedef struct {
        int lo;
        int hi;
        int n;
        int exp_err;
        int exp_len;
    } vec_t;

    always #5 clk = ~clk;

    updn_sweep_ctrl #(.WIDTH(WIDTH), .CYC_W(CYC_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
`ifdef SWEEP_PAUSE_EN
        .pause    (pause),
`endif
        .lo       (lo),
        .hi       (hi),
        .n_sweeps (n_sweeps),
        .count    (count),
        .mod      (mod),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err),
        .sweeps   (sweeps)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected outputs k cycles after the start edge, straight from the sweep geometry.
    task automatic model_at(input int l, input int h, input int n, input int k,
                            output int c, output int m, output int b, output int d, output int s);
        int span, p, ph;
        span = h - l;
        p = k - 1;
        if (p < 2 * span * n) begin
            ph = p % (2 * span);
            s  = p / (2 * span);
            c  = (ph <= span) ? l + ph : l + 2 * span - ph;
            m  = (ph < span) ? 1 : 0;
            b  = 1;
            d  = 0;
        end else begin
            c = l;
            m = 2;
            b = 0;
            d = (p == 2 * span * n) ? 1 : 0;
            s = n;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int c, m, b, d, s, last, done_cnt, len;
        lo = WIDTH'(v.lo);
        hi = WIDTH'(v.hi);
        n_sweeps = CYC_W'(v.n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (v.exp_err != 0) begin
            chk("cfg_err_pulse", int'(cfg_err), 1);
            chk("err_busy", int'(busy), 0);
            chk("err_mod", int'(mod), 2);
            chk("err_count", int'(count), exp_idle_count);
            chk("err_sweeps", int'(sweeps), exp_idle_sweeps);
            @(negedge clk);
            chk("cfg_err_clear", int'(cfg_err), 0);
            chk("err_still_idle", int'(busy), 0);
        end else begin
            last = 2 * (v.hi - v.lo) * v.n + 2;
            done_cnt = 0;
            len = 0;
            for (int k = 1; k <= last; k++) begin
                model_at(v.lo, v.hi, v.n, k, c, m, b, d, s);
                chk("count", int'(count), c);
                chk("mod", int'(mod), m);
                chk("busy", int'(busy), b);
                chk("done", int'(done), d);
                chk("sweeps", int'(sweeps), s);
                chk("no_cfg_err", int'(cfg_err), 0);
                if (done) begin
                    done_cnt++;
                    if (len == 0) len = k + 1;
                end
                // live inputs and stray starts must not disturb a running sweep
                if (k < last) begin
                    lo = WIDTH'($urandom);
                    hi = WIDTH'($urandom);
                    n_sweeps = CYC_W'($urandom);
                    start = ($urandom_range(0, 3) == 0);
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
            chk("run_len", len, v.exp_len);
            chk("done_pulses", done_cnt, 1);
            exp_idle_count = v.lo;
            exp_idle_sweeps = v.n;
        end
    endtask

`ifdef SWEEP_PAUSE_EN
    int  len_p = 0;
    bit  pause_seen = 1'b0;
`endif

    initial begin : main
        vec_t tbl[6];
        vec_t rv;
        bit   found;
        int   span;

        tbl[0] = '{lo: 2, hi: 5,   n: 2, exp_err: 0, exp_len: 14};
        tbl[1] = '{lo: 7, hi: 7,   n: 3, exp_err: 1, exp_len: 0};
        tbl[2] = '{lo: 1, hi: 4,   n: 0, exp_err: 1, exp_len: 0};
        tbl[3] = '{lo: 0, hi: 255, n: 1, exp_err: 0, exp_len: 512};
        tbl[4] = '{lo: 3, hi: 4,   n: 1, exp_err: 0, exp_len: 4};
        tbl[5] = '{lo: 9, hi: 3,   n: 2, exp_err: 1, exp_len: 0};

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_mod", int'(mod), 2);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_sweeps", int'(sweeps), 0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // abort in DOWN at count 4, with a start pulse during busy along the way
        lo = 8'd1; hi = 8'd6; n_sweeps = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            if (count == 8'd4 && mod == 2'd0) begin
                found = 1'b1;
            end else begin
                start = (k == 2);
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk("abort_reach_down4", int'(found), 1);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_count", int'(count), 4);
        chk("abort_mod", int'(mod), 2);
        chk("abort_busy", int'(busy), 0);
        chk("abort_sweeps", int'(sweeps), 0);
        chk("abort_done", int'(done), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_idle_done", int'(done), 0);
            chk("abort_idle_count", int'(count), 4);
        end
        exp_idle_count = 4;
        exp_idle_sweeps = 0;

        // asynchronous reset mid-run, checked between clock edges
        lo = 8'd0; hi = 8'd9; n_sweeps = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (count == 8'd3) found = 1'b1;
            else @(negedge clk);
        end
        chk("rst_reach_3", int'(found), 1);
        rst = 1'b0;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_mod", int'(mod), 2);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_sweeps", int'(sweeps), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_done", int'(done), 0);
        exp_idle_count = 0;
        exp_idle_sweeps = 0;

        // randomized runs, some with illegal configurations
        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 3) == 0) begin
                rv.lo = $urandom_range(0, 255);
                rv.hi = (rv.lo > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, rv.lo) : rv.lo;
                rv.n = $urandom_range(0, 3);
                rv.exp_err = 1;
                rv.exp_len = 0;
            end else begin
                span = $urandom_range(1, 6);
                rv.lo = $urandom_range(0, 255 - span);
                rv.hi = rv.lo + span;
                rv.n = $urandom_range(1, 3);
                rv.exp_err = 0;
                rv.exp_len = 2 * span * rv.n + 2;
            end
            run_vec(rv);
        end

`ifdef SWEEP_PAUSE_EN
        lo = 8'd0; hi = 8'd6; n_sweeps = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 60 && len_p == 0; k++) begin
            if (done) begin
                len_p = k + 1;
            end else if (!pause_seen && count == 8'd3 && mod == 2'd1) begin
                pause_seen = 1'b1;
                pause = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    k++;
                    chk("pause_count", int'(count), 3);
                    chk("pause_mod", int'(mod), 2);
                    chk("pause_busy", int'(busy), 1);
                end
                pause = 1'b0;
            end
            if (len_p == 0) @(negedge clk);
        end
        chk("pause_run_len", len_p, 19);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
